// File: rtl/burst_rule_driver.sv
`default_nettype none
// ============================================================================
// Module      : burst_rule_driver
// Description : Initiator side of the burst-mode handshake. On a start request
//               it drops burst_mode, waits GAP_CYCLES, then drives irdy and
//               trdy low together for BEATS cycles, then restores idle levels.
//               A burst can be cut short with abort.
// Revision    : 1.0 - initial release
// ============================================================================
module burst_rule_driver #(
  parameter int GAP_CYCLES = 2,
  parameter int BEATS      = 7,
  parameter int CNT_W      = 4
) (
  input  logic             mclk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             burst_mode,
  output logic             irdy,
  output logic             trdy,
  output logic [CNT_W-1:0] beat_idx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_t;

  // Terminal counts; the counter never wraps, it reloads on every state entry.
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BEATS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             aborted_nxt;

  // State and counter register.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and counter logic; abort takes priority over the terminal count.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    aborted_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end
      end
      GAP: begin
        if (abort) begin
          state_nxt   = DONE;
          cnt_nxt     = '0;
          aborted_nxt = 1'b1;
        end else if (cnt == GAP_LAST) begin
          state_nxt = XFER;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      XFER: begin
        if (abort) begin
          state_nxt   = DONE;
          cnt_nxt     = '0;
          aborted_nxt = 1'b1;
        end else if (cnt == BEAT_LAST) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state
  // they describe; irdy and trdy share one decode so they always move together.
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      burst_mode <= 1'b1;
      irdy       <= 1'b1;
      trdy       <= 1'b1;
      beat_idx   <= '0;
    end else begin
      busy       <= (state_nxt != IDLE);
      done       <= (state_nxt == DONE);
      aborted    <= aborted_nxt;
      burst_mode <= !((state_nxt == GAP) || (state_nxt == XFER));
      irdy       <= (state_nxt != XFER);
      trdy       <= (state_nxt != XFER);
      beat_idx   <= (state_nxt == XFER) ? cnt_nxt : '0;
    end
  end

endmodule
`default_nettype wire
